shift_seq_ctrl: RTL

Command-driven sequencer for the 8-bit shift/rotate datapath. Accepts one command (data word, operation, shift count) over a valid/ready handshake and applies a single-position shift or rotate once per clock for the requested count. Returns the result over a second valid/ready handshake. Sits between a requesting engine and the shift datapath, replacing direct per-cycle load/op driving.

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_step.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
//   Shared definitions for the shift/rotate command sequencer.
//   - OP_* : two-bit operation encoding carried on cmd_op
//   - state_t : sequencer states (IDLE, SHIFT, DONE)
package shift_seq_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
//   Purely combinational single-position shift or rotate of one word.
//   Ports:
//     word     in   WIDTH  operand
//     op       in   2      OP_SLL / OP_SRL / OP_ROL / OP_ROR
//     step_out out  WIDTH  operand moved by exactly one bit position
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] step_out
);

    // Logical shifts fill with zero; rotates recirculate the bit that
    // falls off the opposite end.
    always_comb begin
        step_out = word;
        case (op)
            OP_SLL:  step_out = {word[WIDTH-2:0], 1'b0};
            OP_SRL:  step_out = {1'b0, word[WIDTH-1:1]};
            OP_ROL:  step_out = {word[WIDTH-2:0], word[WIDTH-1]};
            OP_ROR:  step_out = {word[0], word[WIDTH-1:1]};
            default: step_out = word;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Command-driven sequencer for the shift/rotate datapath. A command
//   (word, op, count) is accepted over a valid/ready handshake, one
//   single-position step is applied per clock for 'count' clocks, and the
//   result is returned over a second valid/ready handshake.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_an     in   1      asynchronous active-low reset
//     cmd_valid  in   1      command present
//     cmd_ready  out  1      high only in IDLE
//     cmd_data   in   WIDTH  operand word
//     cmd_op     in   2      operation (see shift_seq_pkg)
//     cmd_cnt    in   CNT_W  number of steps, 0 allowed
//     abort      in   1      cancel in-flight command (SHIFT or DONE)
//     res_valid  out  1      result available (DONE)
//     res_ready  in   1      consumer takes result
//     res_data   out  WIDTH  result word
//     busy       out  1      high whenever not IDLE
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [1:0]       op;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] step_word;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word     (work),
        .op       (op),
        .step_out (step_word)
    );

    // Sequencer. The work register doubles as the result register, so it
    // naturally holds steady in DONE while the consumer back-pressures.
    // abort takes priority over both stepping and result delivery.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state     <= IDLE;
            work      <= '0;
            op        <= OP_SLL;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        work      <= cmd_data;
                        op        <= cmd_op;
                        remaining <= cmd_cnt;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (remaining == '0) begin
                        state <= DONE;
                    end else begin
                        work      <= step_word;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (abort || res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decode from state only, so no input reaches an output
    // combinationally.
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = work;

endmodule
